// File: rtl/pingpong_addr_ctrl.sv
// Ping-pong BRAM address controller: fills two banks with incoming samples and
// streams each completed frame to the consumer until it is released.
module pingpong_addr_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] load,
    input  logic              s_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bank,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              rd_last,
    output logic              frame_rdy,
    input  logic              proc_done,
    input  logic              ovr_clr,
    output logic              overrun
);
    typedef enum logic {W_FILL, W_STALL} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_STREAM, R_HOLD} rstate_e;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    wstate_e           wst_q;
    rstate_e           rdst_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, load_q;
    logic [ADDR_W-1:0] len_q [2];
    logic              wr_bank_q, rd_bank_q, overrun_q;
    logic [1:0]        bank_full_q, bank_full_d, full_set, full_clr;
    logic              wr_done, rd_accept, rd_release, overrun_d;

    assign wr_en      = s_valid && (wst_q == W_FILL) && (load_q != '0);
    assign wr_done    = wr_en && (wr_addr_q == load_q - ONE);
    assign rd_valid   = (rdst_q == R_STREAM);
    assign rd_last    = rd_valid && (rd_addr_q == len_q[rd_bank_q] - ONE);
    assign rd_accept  = rd_valid && rd_ready;
    assign rd_release = (rdst_q == R_HOLD) && proc_done;
    assign frame_rdy  = (rdst_q == R_STREAM) || (rdst_q == R_HOLD);

    assign wr_addr = wr_addr_q;
    assign wr_bank = wr_bank_q;
    assign rd_addr = rd_addr_q;
    assign rd_bank = rd_bank_q;
    assign overrun = overrun_q;

    // The writer only sets the bank it is filling (never full) and the reader
    // only clears the bank it holds (always full), so the masks never collide.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        full_set[wr_bank_q] = wr_done;
        full_clr[rd_bank_q] = rd_release;
        bank_full_d = (bank_full_q & ~full_clr) | full_set;
        overrun_d   = ((wst_q == W_STALL) && s_valid) || (overrun_q && !ovr_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            overrun_q   <= overrun_d;
        end
    end

    // Writer: frame length is latched while parked at address 0, so a load
    // change mid-frame only affects the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q     <= W_FILL;
            wr_addr_q <= '0;
            wr_bank_q <= 1'b0;
            load_q    <= '0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
        end else if (wst_q == W_FILL) begin
            if (wr_addr_q == '0)
                load_q <= load;
            if (wr_done) begin
                wr_addr_q        <= '0;
                len_q[wr_bank_q] <= load_q;
                if (!bank_full_q[~wr_bank_q])
                    wr_bank_q <= ~wr_bank_q;
                else
                    wst_q <= W_STALL;
            end else if (wr_en) begin
                wr_addr_q <= wr_addr_q + ONE;
            end
        end else begin
            if (!bank_full_q[~wr_bank_q]) begin
                wr_bank_q <= ~wr_bank_q;
                wst_q     <= W_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdst_q    <= R_IDLE;
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            case (rdst_q)
                R_IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        rdst_q    <= R_STREAM;
                        rd_addr_q <= '0;
                    end
                end
                R_STREAM: begin
                    if (rd_accept) begin
                        if (rd_last)
                            rdst_q <= R_HOLD;
                        else
                            rd_addr_q <= rd_addr_q + ONE;
                    end
                end
                R_HOLD: begin
                    if (proc_done) begin
                        rd_bank_q <= ~rd_bank_q;
                        rdst_q    <= R_IDLE;
                    end
                end
                default: rdst_q <= R_IDLE;
            endcase
        end
    end
endmodule
